// File: rtl/chess_pkg.sv
// Shared types and constants for the chess board front end: squares, move-entry
// FSM states and the mailbox command word layout.
package chess_pkg;

    typedef logic [5:0] square_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HAVE_FROM,
        S_RD_REQ,
        S_RD_WAIT,
        S_CHECK,
        S_WR
    } state_t;

    localparam int          CMD_VALID_BIT        = 31;
    localparam int          CMD_FROM_LSB         = 6;
    localparam int          CMD_TO_LSB           = 0;
    localparam logic [11:0] DEFAULT_MAILBOX_ADDR = 12'd40;

    function automatic logic [31:0] make_cmd(square_t from_sq, square_t to_sq);
        logic [31:0] cmd;
        cmd                      = '0;
        cmd[CMD_VALID_BIT]       = 1'b1;
        cmd[CMD_FROM_LSB +: 6]   = from_sq;
        cmd[CMD_TO_LSB +: 6]     = to_sq;
        return cmd;
    endfunction

    // Rank/file step that sticks at the board edge instead of wrapping.
    function automatic logic [2:0] sat_step(logic [2:0] v, logic inc);
        if (inc) begin
            return (v == 3'd7) ? v : v + 3'd1;
        end
        return (v == 3'd0) ? v : v - 3'd1;
    endfunction

endpackage

// File: rtl/move_entry_ctrl_if.sv
// Port-B mailbox access bus shared with the VGA reader through an external arbiter.
interface move_entry_ctrl_if;

    logic        mem_req;
    logic        mem_gnt;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wren;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        output mem_wdata,
        output mem_wren,
        input  mem_gnt,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wren,
        output mem_gnt,
        output mem_rdata
    );

endinterface

// File: rtl/button_debounce.sv
// One push-button: two-flop synchroniser, stability counter and a single-cycle
// press pulse when the accepted level rises.
module button_debounce
    import chess_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            level_d = ~level_q;
            cnt_d   = '0;
            press_d = ~level_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/move_entry_ctrl.sv
// Player move entry: debounced buttons drive a board cursor and from/to selection;
// each completed move is posted into the dmem mailbox once the processor has drained it.
module move_entry_ctrl
    import chess_pkg::*;
#(
    parameter logic [11:0] MAILBOX_ADDR    = DEFAULT_MAILBOX_ADDR,
    parameter int          DEBOUNCE_CYCLES = 1000000,
    parameter int          CNT_W           = 20
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     btn_up,
    input  logic                     btn_down,
    input  logic                     btn_left,
    input  logic                     btn_right,
    input  logic                     btn_sel,
    input  logic                     btn_cancel,
    move_entry_ctrl_if.master        mem,
    output square_t                  cursor_sq,
    output square_t                  from_sq,
    output logic                     from_valid,
    output logic                     busy,
    output logic                     move_sent
);

    logic p_up, p_down, p_left, p_right, p_sel, p_cancel;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_up (
        .clock(clock), .reset(reset), .btn_raw(btn_up), .press(p_up));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_down (
        .clock(clock), .reset(reset), .btn_raw(btn_down), .press(p_down));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_left (
        .clock(clock), .reset(reset), .btn_raw(btn_left), .press(p_left));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_right (
        .clock(clock), .reset(reset), .btn_raw(btn_right), .press(p_right));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_sel (
        .clock(clock), .reset(reset), .btn_raw(btn_sel), .press(p_sel));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_cancel (
        .clock(clock), .reset(reset), .btn_raw(btn_cancel), .press(p_cancel));

    state_t      state_q, state_d;
    square_t     cursor_q, cursor_d;
    square_t     from_q, from_d;
    square_t     to_q, to_d;
    logic        from_valid_q, from_valid_d;
    logic        req_q, req_d;
    logic        wren_q, wren_d;
    logic [11:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  rank, file;
    logic        selecting;

    always_comb begin
        state_d      = state_q;
        cursor_d     = cursor_q;
        from_d       = from_q;
        to_d         = to_q;
        from_valid_d = from_valid_q;
        req_d        = req_q;
        wren_d       = wren_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rank         = cursor_q[5:3];
        file         = cursor_q[2:0];
        selecting    = (state_q == S_IDLE) || (state_q == S_HAVE_FROM);

        // Only the highest-priority pulse acts; the rest of that cycle's pulses are lost.
        if (selecting) begin
            if (p_cancel) begin
                if (state_q == S_HAVE_FROM) begin
                    from_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end else if (p_sel) begin
                if (state_q == S_IDLE) begin
                    from_d       = cursor_q;
                    from_valid_d = 1'b1;
                    state_d      = S_HAVE_FROM;
                end else if (cursor_q == from_q) begin
                    from_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end else begin
                    to_d    = cursor_q;
                    req_d   = 1'b1;
                    wren_d  = 1'b0;
                    addr_d  = MAILBOX_ADDR;
                    state_d = S_RD_REQ;
                end
            end else if (p_up) begin
                cursor_d = {sat_step(rank, 1'b1), file};
            end else if (p_down) begin
                cursor_d = {sat_step(rank, 1'b0), file};
            end else if (p_left) begin
                cursor_d = {rank, sat_step(file, 1'b0)};
            end else if (p_right) begin
                cursor_d = {rank, sat_step(file, 1'b1)};
            end
        end

        case (state_q)
            S_RD_REQ: begin
                if (mem.mem_gnt) begin
                    req_d   = 1'b0;
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: state_d = S_CHECK;
            S_CHECK: begin
                // A still-valid mailbox means the processor has not consumed the last move.
                req_d = 1'b1;
                if (mem.mem_rdata[CMD_VALID_BIT]) begin
                    state_d = S_RD_REQ;
                end else begin
                    wren_d  = 1'b1;
                    wdata_d = make_cmd(from_q, to_q);
                    state_d = S_WR;
                end
            end
            S_WR: begin
                if (mem.mem_gnt) begin
                    req_d        = 1'b0;
                    wren_d       = 1'b0;
                    from_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cursor_q     <= '0;
            from_q       <= '0;
            to_q         <= '0;
            from_valid_q <= 1'b0;
            req_q        <= 1'b0;
            wren_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cursor_q     <= cursor_d;
            from_q       <= from_d;
            to_q         <= to_d;
            from_valid_q <= from_valid_d;
            req_q        <= req_d;
            wren_q       <= wren_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_wren  = wren_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    assign cursor_sq  = cursor_q;
    assign from_sq    = from_q;
    assign from_valid = from_valid_q;
    assign busy       = !selecting;
    assign move_sent  = (state_q == S_WR) && mem.mem_gnt;

endmodule

// File: tb/tb_move_entry_ctrl.sv
// Randomised bench for move_entry_ctrl: a square/selection model fed by button presses,
// plus an arbiter/mailbox model on port B.
module tb_move_entry_ctrl;
    import chess_pkg::*;

    localparam int DB = 4;

    logic clock = 1'b0;
    logic reset;
    logic btn_up, btn_down, btn_left, btn_right, btn_sel, btn_cancel;
    square_t cursor_sq, from_sq;
    logic from_valid, busy, move_sent;

    move_entry_ctrl_if mem_if ();

    move_entry_ctrl #(
        .MAILBOX_ADDR(12'd40), .DEBOUNCE_CYCLES(DB), .CNT_W(4)
    ) dut (
        .clock(clock), .reset(reset),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_sel(btn_sel), .btn_cancel(btn_cancel),
        .mem(mem_if),
        .cursor_sq(cursor_sq), .from_sq(from_sq), .from_valid(from_valid),
        .busy(busy), .move_sent(move_sent)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- arbiter + mailbox model ----------------
    int          cyc = 0;
    int          gnt_dly = 0, wait_cnt = 0, busy_polls = 0;
    bit          block_wr = 0;
    int          n_reads = 0, n_writes = 0, n_sent = 0, sel_pulses = 0;
    int          last_sel_pulse_cyc = -1, reads_at_write = 0;
    logic [31:0] last_wdata = '0;
    logic [11:0] last_waddr = '0, last_raddr = '0;
    logic [31:0] rd_pipe0, rd_pipe1;
    logic        prev_pending;
    logic [45:0] prev_bundle;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        mem_if.mem_gnt   = 1'b0;
        mem_if.mem_rdata = '1;
        rd_pipe0         = '1;
        rd_pipe1         = '1;
        prev_pending     = 1'b0;
        prev_bundle      = '0;
        forever begin
            @(negedge clock);
            if (prev_pending && !reset)
                check("req_hold", {mem_if.mem_req, mem_if.mem_wren, mem_if.mem_addr, mem_if.mem_wdata},
                      prev_bundle);
            if (mem_if.mem_req && !reset) begin
                if (wait_cnt >= gnt_dly && !(block_wr && mem_if.mem_wren)) begin
                    mem_if.mem_gnt = 1'b1;
                    wait_cnt = 0;
                end else begin
                    mem_if.mem_gnt = 1'b0;
                    wait_cnt++;
                end
            end else begin
                mem_if.mem_gnt = 1'b0;
                wait_cnt = 0;
            end
            mem_if.mem_rdata = rd_pipe1;
            rd_pipe1 = rd_pipe0;
            rd_pipe0 = '1;
            if (mem_if.mem_req && mem_if.mem_gnt) begin
                if (mem_if.mem_wren) begin
                    n_writes++;
                    last_wdata     = mem_if.mem_wdata;
                    last_waddr     = mem_if.mem_addr;
                    reads_at_write = n_reads;
                end else begin
                    n_reads++;
                    last_raddr = mem_if.mem_addr;
                    if (busy_polls > 0) begin
                        rd_pipe0 = 32'h8000_0000;
                        busy_polls--;
                    end else begin
                        rd_pipe0 = 32'h0;
                    end
                end
            end
            prev_pending = mem_if.mem_req && !mem_if.mem_gnt && !reset;
            prev_bundle  = {mem_if.mem_req, mem_if.mem_wren, mem_if.mem_addr, mem_if.mem_wdata};
            #1;
            if (move_sent) n_sent++;
            if (dut.u_db_sel.press_q) begin
                sel_pulses++;
                last_sel_pulse_cyc = cyc;
            end
        end
    end

    // ---------------- reference model ----------------
    int m_rank = 0, m_file = 0, m_from = 0, m_fv = 0;

    task automatic model_press(input logic [5:0] m, output bit commit, output logic [31:0] cmd);
        int cur;
        cur    = m_rank * 8 + m_file;
        commit = 0;
        cmd    = '0;
        if (m[5]) begin
            m_fv = 0;
        end else if (m[4]) begin
            if (m_fv == 0) begin
                m_from = cur;
                m_fv   = 1;
            end else if (cur == m_from) begin
                m_fv = 0;
            end else begin
                commit = 1;
                cmd    = 32'h8000_0000 + 32'(m_from * 64) + 32'(cur);
                m_fv   = 0;
            end
        end else if (m[0]) m_rank = (m_rank < 7) ? m_rank + 1 : 7;
        else if (m[1])     m_rank = (m_rank > 0) ? m_rank - 1 : 0;
        else if (m[2])     m_file = (m_file > 0) ? m_file - 1 : 0;
        else if (m[3])     m_file = (m_file < 7) ? m_file + 1 : 7;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drive_btn(input logic [5:0] m);
        {btn_cancel, btn_sel, btn_right, btn_left, btn_down, btn_up} = m;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 1000 && busy; i++) tick(1);
        check("idle_reached", busy, 1'b0);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_cursor"}, cursor_sq, 64'(m_rank * 8 + m_file));
        check({tag, "_from_valid"}, from_valid, 64'(m_fv));
        check({tag, "_from_sq"}, from_sq, 64'(m_from));
    endtask

    task automatic do_press(input logic [5:0] m);
        int w0, s0, r0, polls;
        bit commit;
        logic [31:0] cmd;
        w0 = n_writes; s0 = n_sent; r0 = n_reads; polls = busy_polls;
        model_press(m, commit, cmd);
        drive_btn(m);
        tick(10);
        drive_btn('0);
        tick(10);
        if (commit) wait_idle();
        check("writes", n_writes - w0, 64'(commit));
        check("sent", n_sent - s0, 64'(commit));
        check("reads", n_reads - r0, commit ? 64'(polls + 1) : 64'd0);
        if (commit) begin
            check("wdata", last_wdata, cmd);
            check("waddr", last_waddr, 12'd40);
            check("raddr", last_raddr, 12'd40);
        end
        check_state("press");
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cursor"}, cursor_sq, 0);
        check({tag, "_from"}, from_sq, 0);
        check({tag, "_fv"}, from_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_sent"}, move_sent, 0);
        check({tag, "_req"}, mem_if.mem_req, 0);
        check({tag, "_wren"}, mem_if.mem_wren, 0);
        check({tag, "_addr"}, mem_if.mem_addr, 0);
        check({tag, "_wdata"}, mem_if.mem_wdata, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, raw_cyc, w0, s0, r0, pr0;
        bit commit;
        logic [31:0] cmd;
        logic [5:0] m;

        reset = 1'b1;
        drive_btn('0);
        tick(3);
        check_reset_vals("in_reset");
        reset = 1'b0;
        tick(2);
        check_reset_vals("after_reset");

        // short glitch is filtered
        p0 = sel_pulses;
        btn_sel = 1'b1;
        tick(3);
        btn_sel = 1'b0;
        tick(12);
        check("glitch_pulses", sel_pulses - p0, 0);
        check("glitch_fv", from_valid, 0);

        // held press: one pulse, DEBOUNCE_CYCLES+3 after the raw edge
        p0 = sel_pulses;
        raw_cyc = cyc;
        model_press(6'b010000, commit, cmd);
        btn_sel = 1'b1;
        tick(12);
        btn_sel = 1'b0;
        tick(10);
        check("held_pulses", sel_pulses - p0, 1);
        check("held_latency", last_sel_pulse_cyc - raw_cyc, DB + 3);
        check_state("held");
        do_press(6'b100000);

        // edge saturation from square 0
        do_press(6'b000100);
        do_press(6'b000010);
        for (int i = 0; i < 9; i++) do_press(6'b001000);
        check("sat_right", cursor_sq, 7);

        // 12 -> 28, mailbox empty, grant 2 cycles after request
        for (int i = 0; i < 3; i++) do_press(6'b000100);
        do_press(6'b000001);
        check("at_12", cursor_sq, 12);
        do_press(6'b010000);
        do_press(6'b000001);
        do_press(6'b000001);
        gnt_dly = 2;
        busy_polls = 0;
        do_press(6'b010000);
        check("cmd_031c", last_wdata, 32'h8000_031C);

        // mailbox full for three polls; cursor press during the commit is ignored
        do_press(6'b000010);
        do_press(6'b000010);
        do_press(6'b010000);
        do_press(6'b000001);
        do_press(6'b000001);
        gnt_dly = 6;
        busy_polls = 3;
        w0 = n_writes; s0 = n_sent; r0 = n_reads;
        model_press(6'b010000, commit, cmd);
        drive_btn(6'b010000);
        tick(12);
        check("poll_busy", busy, 1);
        drive_btn(6'b000001);
        tick(10);
        drive_btn('0);
        tick(10);
        wait_idle();
        check("poll_reads", n_reads - r0, 4);
        check("poll_reads_before_wr", reads_at_write - r0, 4);
        check("poll_writes", n_writes - w0, 1);
        check("poll_sent", n_sent - s0, 1);
        check("poll_cmd", last_wdata, 32'h8000_031C);
        check_state("poll");
        gnt_dly = 1;

        // deselect, cancel, and cancel beating sel
        do_press(6'b000010);
        do_press(6'b000010);
        do_press(6'b010000);
        do_press(6'b010000);
        do_press(6'b010000);
        do_press(6'b100000);
        do_press(6'b010000);
        do_press(6'b110000);

        // random traffic
        for (int it = 0; it < 60; it++) begin
            m = 6'(1 << $urandom_range(0, 5));
            if ($urandom_range(0, 3) == 0) m = 6'b010000;
            if ($urandom_range(0, 4) == 0) m = m | 6'(1 << $urandom_range(0, 5));
            gnt_dly = $urandom_range(0, 3);
            busy_polls = $urandom_range(0, 2);
            do_press(m);
        end
        busy_polls = 0;
        gnt_dly = 0;

        // reset while the write waits for a grant
        if (m_fv != 0) do_press(6'b100000);
        do_press(6'b010000);
        do_press((m_rank < 7) ? 6'b000001 : 6'b000010);
        block_wr = 1;
        w0 = n_writes; s0 = n_sent;
        drive_btn(6'b010000);
        for (int i = 0; i < 200 && !mem_if.mem_wren; i++) tick(1);
        check("wr_reached", mem_if.mem_wren, 1);
        tick(3);
        #2;
        reset = 1'b1;
        drive_btn('0);
        #1;
        check("async_req_drop", mem_if.mem_req, 0);
        check("async_wren_drop", mem_if.mem_wren, 0);
        tick(2);
        check_reset_vals("mid_commit");
        check("abort_writes", n_writes - w0, 0);
        check("abort_sent", n_sent - s0, 0);
        reset = 1'b0;
        block_wr = 0;
        m_rank = 0; m_file = 0; m_from = 0; m_fv = 0;
        tick(3);
        check("post_abort_busy", busy, 0);
        pr0 = n_writes;
        do_press(6'b000001);
        do_press(6'b001000);
        check("post_abort_cursor", cursor_sq, 9);
        check("post_abort_writes", n_writes - pr0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
